// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS core pipeline control:
// Tnew/Tuse encoding, register-number width, mult/div latencies and
// the busy-timer state type.
package cpu_pkg;

   // Tnew / Tuse are 2-bit cycle counts; Tuse = 3 marks an unused source.
   localparam int              TW        = 2;
   localparam logic [TW-1:0]   TUSE_NONE = 2'd3;

   // Architectural register number width.
   localparam int              REG_W     = 5;

   // Default busy latencies of the multi-cycle mult/div unit.
   localparam int              MULT_CYC_DEF = 5;
   localparam int              DIV_CYC_DEF  = 10;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_busy_timer.sv
// Busy timer for the multi-cycle mult/div unit. A start in IDLE loads the
// down-counter with the operation latency; busy stays high for exactly that
// many cycles. Starts while BUSY are ignored (no reload).
module md_busy_timer
   import cpu_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF,
   parameter int CNT_W    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic busy
);

   md_state_e        r_state;
   md_state_e        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   // State and counter registers; reset abandons any pending operation.
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic: load on start, count down, leave BUSY when count hits 0.
   always_comb begin
      // NOTE: hold values are assigned first so no path leaves an output unassigned (no latch).
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         MD_IDLE: begin
            if (start) begin
               w_state_nxt = MD_BUSY;
               w_cnt_nxt   = is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            end
         end
         MD_BUSY: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = MD_IDLE;
            end
         end
      endcase
   end

   assign busy = (r_state == MD_BUSY);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/bubble controller: compares D-stage Tuse against E/M Tnew,
// blocks md instructions while the mult/div unit is busy, and drives the
// F/D enables and E clear. Optional stall counter: STALL_CTRL_PERF_EN.
module stall_ctrl
   import cpu_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] D_rs,
   input  logic [REG_W-1:0] D_rt,
   input  logic [TW-1:0]    D_tuse_rs,
   input  logic [TW-1:0]    D_tuse_rt,
   input  logic             D_is_md,
   input  logic [REG_W-1:0] E_A3,
   input  logic [REG_W-1:0] M_A3,
   input  logic [TW-1:0]    E_tnew,
   input  logic [TW-1:0]    M_tnew,
   input  logic             E_md_start,
   input  logic             E_md_div,
   output logic             F_en,
   output logic             D_en,
   output logic             E_clr,
   output logic             md_busy
`ifdef STALL_CTRL_PERF_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);

   logic w_haz_rs;
   logic w_haz_rt;
   logic w_haz_md;
   logic w_stall;

   // A source stalls when a pending E or M result arrives later than D needs it.
   // Register 0 is hard-wired and never hazards; Tuse = 3 never loses to a 2-bit Tnew.
   function automatic logic src_hazard(input logic [REG_W-1:0] src,
                                       input logic [TW-1:0]    tuse);
      return (src != '0) &&
             (((src == E_A3) && (E_tnew > tuse)) ||
              ((src == M_A3) && (M_tnew > tuse)));
   endfunction

   md_busy_timer #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC),
      .CNT_W    (CNT_W)
   ) u_md_busy_timer (
      .clk    (clk),
      .reset  (reset),
      .start  (E_md_start),
      .is_div (E_md_div),
      .busy   (md_busy)
   );

   assign w_haz_rs = src_hazard(D_rs, D_tuse_rs);
   assign w_haz_rt = src_hazard(D_rt, D_tuse_rt);
   // An md op starting in E this cycle is not yet reflected in md_busy.
   assign w_haz_md = D_is_md && (md_busy || E_md_start);
   assign w_stall  = w_haz_rs || w_haz_rt || w_haz_md;

   assign F_en  = !w_stall;
   assign D_en  = !w_stall;
   assign E_clr = w_stall;

`ifdef STALL_CTRL_PERF_EN
   logic [31:0] r_stall_cnt;

   // Count stalled cycles; wraps naturally at 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed hazard table, hand-written
// mult/div/reset sequences, then randomized traffic against a reference model.
module tb_stall_ctrl;

   logic       clk;
   logic       reset;
   logic [4:0] D_rs, D_rt, E_A3, M_A3;
   logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
   logic       D_is_md, E_md_start, E_md_div;
   logic       F_en, D_en, E_clr, md_busy;
`ifdef STALL_CTRL_PERF_EN
   logic [31:0] stall_cnt;
`endif

   int n_chk;
   int n_err;
   int m_busy_left;   // model: remaining busy cycles of the mult/div unit

   stall_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .D_rs       (D_rs),
      .D_rt       (D_rt),
      .D_tuse_rs  (D_tuse_rs),
      .D_tuse_rt  (D_tuse_rt),
      .D_is_md    (D_is_md),
      .E_A3       (E_A3),
      .M_A3       (M_A3),
      .E_tnew     (E_tnew),
      .M_tnew     (M_tnew),
      .E_md_start (E_md_start),
      .E_md_div   (E_md_div),
      .F_en       (F_en),
      .D_en       (D_en),
      .E_clr      (E_clr),
      .md_busy    (md_busy)
`ifdef STALL_CTRL_PERF_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs, rt, e_a3, m_a3;
      logic [1:0] tuse_rs, tuse_rt, e_tnew, m_tnew;
      logic       is_md;
      logic       exp_stall;
   } vec_t;

   vec_t vec[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      D_rs = 0; D_rt = 0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_is_md = 0;
      E_A3 = 0; M_A3 = 0; E_tnew = 0; M_tnew = 0; E_md_start = 0; E_md_div = 0;
   endtask

   // Advance one clock, update the reference timer from the inputs seen at the edge.
   task automatic tick();
      @(posedge clk);
      if (m_busy_left > 0) m_busy_left--;
      else if (E_md_start) m_busy_left = E_md_div ? 10 : 5;
      #1;
   endtask

   function automatic logic ref_src_haz(input logic [4:0] src, input logic [1:0] tuse);
      int need, e_avail, m_avail;
      need    = int'(tuse);
      e_avail = int'(E_tnew);
      m_avail = int'(M_tnew);
      if (src == 0) return 1'b0;
      if (src == E_A3 && e_avail > need) return 1'b1;
      if (src == M_A3 && m_avail > need) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic ref_stall();
      logic md_block;
      md_block = D_is_md && (m_busy_left > 0 || E_md_start);
      return ref_src_haz(D_rs, D_tuse_rs) || ref_src_haz(D_rt, D_tuse_rt) || md_block;
   endfunction

   task automatic check_all(input string name);
      logic s;
      s = ref_stall();
      check({name, ".E_clr"},   32'(E_clr),   32'(s));
      check({name, ".F_en"},    32'(F_en),    32'(!s));
      check({name, ".D_en"},    32'(D_en),    32'(!s));
      check({name, ".md_busy"}, 32'(md_busy), 32'(m_busy_left > 0));
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      m_busy_left = 0;
      idle_inputs();
      reset = 1'b0;

      //              rs  rt  eA3 mA3 tu_rs tu_rt e_tn m_tn md exp
      vec[0] = '{5'd5, 5'd0, 5'd5, 5'd0, 2'd1, 2'd3, 2'd2, 2'd0, 1'b0, 1'b1}; // load-use
      vec[1] = '{5'd5, 5'd0, 5'd5, 5'd0, 2'd1, 2'd3, 2'd1, 2'd0, 1'b0, 1'b0}; // tnew=1 ok
      vec[2] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd3, 2'd2, 2'd0, 1'b0, 1'b0}; // $0
      vec[3] = '{5'd0, 5'd8, 5'd0, 5'd8, 2'd3, 2'd0, 2'd0, 2'd1, 1'b0, 1'b1}; // M hazard
      vec[4] = '{5'd0, 5'd8, 5'd0, 5'd8, 2'd3, 2'd1, 2'd0, 2'd1, 1'b0, 1'b0}; // M ok
      vec[5] = '{5'd3, 5'd0, 5'd3, 5'd3, 2'd1, 2'd3, 2'd0, 2'd2, 1'b0, 1'b1}; // E+M, M stalls
      vec[6] = '{5'd4, 5'd0, 5'd4, 5'd0, 2'd3, 2'd3, 2'd3, 2'd0, 1'b0, 1'b0}; // unused src
      vec[7] = '{5'd0, 5'd7, 5'd7, 5'd0, 2'd3, 2'd0, 2'd1, 2'd0, 1'b0, 1'b1}; // rt E tuse 0
      vec[8] = '{5'd9, 5'd9, 5'd1, 5'd2, 2'd0, 2'd0, 2'd3, 2'd3, 1'b0, 1'b0}; // no match
      vec[9] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0}; // md, idle unit

      // Reset state
      #12;
      check("rst.F_en",    32'(F_en),    32'd1);
      check("rst.D_en",    32'(D_en),    32'd1);
      check("rst.E_clr",   32'(E_clr),   32'd0);
      check("rst.md_busy", 32'(md_busy), 32'd0);
      reset = 1'b1;

`ifdef STALL_CTRL_PERF_EN
      check("perf.rst", stall_cnt, 32'd0);
      D_rs = 5; D_tuse_rs = 1; E_A3 = 5; E_tnew = 2;
      tick(); tick(); tick();
      check("perf.cnt3", stall_cnt, 32'd3);
      force dut.r_stall_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_stall_cnt;
      tick();
      check("perf.wrap", stall_cnt, 32'd0);
      idle_inputs();
`endif

      // Directed hazard table
      for (int i = 0; i < 10; i++) begin
         tick();
         D_rs = vec[i].rs; D_rt = vec[i].rt; E_A3 = vec[i].e_a3; M_A3 = vec[i].m_a3;
         D_tuse_rs = vec[i].tuse_rs; D_tuse_rt = vec[i].tuse_rt;
         E_tnew = vec[i].e_tnew; M_tnew = vec[i].m_tnew; D_is_md = vec[i].is_md;
         E_md_start = 1'b0; E_md_div = 1'b0;
         #2;
         check($sformatf("vec%0d.E_clr", i), 32'(E_clr), 32'(vec[i].exp_stall));
         check($sformatf("vec%0d.F_en", i),  32'(F_en),  32'(!vec[i].exp_stall));
         check($sformatf("vec%0d.D_en", i),  32'(D_en),  32'(!vec[i].exp_stall));
      end

      // Mult: busy exactly 5 cycles, dependent md op issues on cycle 6
      tick();
      idle_inputs();
      D_is_md = 1; E_md_start = 1; E_md_div = 0;
      #2;
      check("mult.start_stall", 32'(E_clr), 32'd1);
      tick();
      E_md_start = 0;
      for (int k = 1; k <= 5; k++) begin
         #2;
         check($sformatf("mult.busy%0d", k),  32'(md_busy), 32'd1);
         check($sformatf("mult.stall%0d", k), 32'(E_clr),   32'd1);
         tick();
      end
      #2;
      check("mult.busy_end", 32'(md_busy), 32'd0);
      check("mult.issue",    32'(F_en),    32'd1);

      // Div interrupted by reset at busy cycle 4
      tick();
      idle_inputs();
      E_md_start = 1; E_md_div = 1;
      tick();
      E_md_start = 0;
      tick(); tick(); tick();
      #2;
      check("div.busy4", 32'(md_busy), 32'd1);
      reset = 1'b0;
      m_busy_left = 0;
      #1;
      check("div.rst_async", 32'(md_busy), 32'd0);
      tick(); tick();
      reset = 1'b1;
      for (int k = 0; k < 12; k++) begin
         #2;
         check($sformatf("div.after_rst%0d", k), 32'(md_busy), 32'd0);
         tick();
      end

      // Randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         D_rs = 5'($urandom_range(0, 3));
         D_rt = 5'($urandom_range(0, 3));
         E_A3 = 5'($urandom_range(0, 3));
         M_A3 = 5'($urandom_range(0, 3));
         D_tuse_rs = 2'($urandom_range(0, 3));
         D_tuse_rt = 2'($urandom_range(0, 3));
         E_tnew = 2'($urandom_range(0, 3));
         M_tnew = 2'($urandom_range(0, 3));
         D_is_md = ($urandom_range(0, 2) == 0);
         E_md_start = ($urandom_range(0, 7) == 0);
         E_md_div = 1'($urandom_range(0, 1));
         #2;
         check_all($sformatf("rnd%0d", n));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
